uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance among N byte-stream requesters using round-robin arbitration.
- Optionally holds the grant for a multi-byte burst (packet) so that requesters' frames do not interleave on the serial line.
- Sits between the requesters and uart_tx: it drives tx_data/tx_valid and consumes tx_ready.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N byte-stream requesters,
// with optional burst hold so frames from different requesters never interleave.
module uart_tx_arbiter #(
  parameter int unsigned N            = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned HOLD_TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int unsigned W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } state_t;

  state_t       state, state_d;
  logic [W-1:0] owner;
  logic [W-1:0] last_grant;
  logic [W-1:0] winner;
  logic [W-1:0] cand;
  logic [W-1:0] sel;
  logic         found;
  logic         load;
  logic         handoff;
  logic         release_now;
  logic         last_flag;
  logic [7:0]   beat_cnt;
  logic [7:0]   hold_cnt;
  logic [8:0]   beat_next;
  logic [7:0]   sel_data;
  logic         sel_last;

  // Search starts one past the last owner that completed a handoff, wrapping at N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = last_grant;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (cand == W'(N - 1)) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign sel = (state == IDLE) ? winner : owner;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == W'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  assign beat_next   = {1'b0, beat_cnt} + 9'd1;
  assign release_now = last_flag || (beat_next == 9'(MAX_BURST));

  always_comb begin
    state_d   = state;
    req_ready = '0;
    load      = 1'b0;
    handoff   = 1'b0;
    case (state)
      IDLE: begin
        if (found && rst) begin
          req_ready[winner] = 1'b1;
          load              = 1'b1;
          state_d           = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          handoff = 1'b1;
          state_d = release_now ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (rst) begin
          req_ready[owner] = 1'b1;
        end
        if (req_valid[owner]) begin
          load    = 1'b1;
          state_d = SEND;
        end else if (hold_cnt == 8'(HOLD_TIMEOUT - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Priority moves only on a completed handoff, so an idle owner costs nobody a turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      last_flag  <= 1'b0;
      owner      <= '0;
      last_grant <= W'(N - 1);
      beat_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      if (load) begin
        tx_data   <= sel_data;
        last_flag <= sel_last;
        tx_valid  <= 1'b1;
      end
      if (load && state == IDLE) begin
        owner    <= winner;
        beat_cnt <= '0;
      end
      if (handoff) begin
        tx_valid   <= 1'b0;
        last_grant <= owner;
        beat_cnt   <= beat_cnt + 1'b1;
        hold_cnt   <= '0;
      end else if (state == HOLD && !load) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign grant_id = owner;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the DUT, a log
// records every tx handoff, and the log is compared with hand-derived orders.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] src_data [4][64];
  logic       src_last [4][64];
  int         src_len [4] = '{0, 0, 0, 0};
  int         src_ptr [4] = '{0, 0, 0, 0};

  logic [7:0] log_data [256];
  int         log_cnt = 0;

  logic [7:0] exp_rr    [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
  logic [7:0] exp_burst [5] = '{8'h20, 8'h01, 8'h02, 8'h03, 8'h21};
  logic [7:0] exp_max   [7] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h50, 8'h34, 8'h35};
  logic [7:0] exp_rst   [4] = '{8'h80, 8'h81, 8'h82, 8'h83};

  uart_tx_arbiter #(
    .N(4),
    .MAX_BURST(4),
    .HOLD_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_data[r][src_len[r]] = d;
    src_last[r][src_len[r]] = l;
    src_len[r]++;
  endtask

  // Requester model: sample handshakes on the falling edge, advance after the rising edge.
  initial begin
    logic [3:0] fire;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 64; j++) begin
        src_data[r][j] = '0;
        src_last[r][j] = 1'b0;
      end
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      if (tx_valid && tx_ready && rst) begin
        log_data[log_cnt] = tx_data;
        log_cnt++;
      end
      @(posedge clk);
      #2;
      for (int r = 0; r < 4; r++) begin
        if (fire[r]) src_ptr[r]++;
        req_valid[r]       = src_ptr[r] < src_len[r];
        req_data[8*r +: 8] = src_data[r][src_ptr[r]];
        req_last[r]        = src_last[r][src_ptr[r]];
      end
    end
  end

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = !busy && !tx_valid;
      for (int r = 0; r < 4; r++)
        if (src_ptr[r] != src_len[r]) done = 1'b0;
    end
    check({"drain_", tag}, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int  base;
    int  cnt;
    bit  seen;

    // Reset state and quiet idle
    @(negedge clk);
    check("rst_state", {tx_valid, busy, req_ready, grant_id}, '0);
    check("rst_data", 32'(tx_data), 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle%0d", c), {tx_valid, busy, req_ready}, '0);
    end

    // Single byte with a stalled uart_tx
    @(posedge clk); #1;
    push(2, 8'hA5, 1'b1);
    @(negedge clk);
    check("single_rdy", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("single_rdy_drop", 32'(req_ready), 32'b0000);
    check("single_valid", 32'(tx_valid), 32'd1);
    check("single_data", 32'(tx_data), 32'hA5);
    check("single_gnt", 32'(grant_id), 32'd2);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d", c), {tx_valid, busy}, 2'b11);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("single_pend", 32'(tx_valid), 32'd1);
    @(negedge clk);
    check("single_done", {tx_valid, busy}, 2'b00);

    // Round-robin from a fresh reset
    do_reset();
    base = log_cnt;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 4; r++) push(r, 8'(8'h10 + r), 1'b1);
    wait_drain("rr");
    check("rr_cnt", log_cnt - base, 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("rr%0d", k), 32'(log_data[base + k]), 32'(exp_rr[k]));

    // Burst lock with a competing requester
    @(posedge clk); #1;
    base = log_cnt;
    push(0, 8'h20, 1'b1);
    push(0, 8'h21, 1'b1);
    push(1, 8'h01, 1'b0);
    push(1, 8'h02, 1'b0);
    push(1, 8'h03, 1'b1);
    wait_drain("burst");
    check("burst_cnt", log_cnt - base, 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("burst%0d", k), 32'(log_data[base + k]), 32'(exp_burst[k]));

    // Forced release after MAX_BURST bytes
    @(posedge clk); #1;
    base = log_cnt;
    for (int k = 0; k < 6; k++) push(3, 8'(8'h30 + k), 1'b0);
    push(0, 8'h50, 1'b1);
    wait_drain("max");
    check("max_cnt", log_cnt - base, 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("max%0d", k), 32'(log_data[base + k]), 32'(exp_max[k]));

    // Hold timeout after a lone byte without last
    @(posedge clk); #1;
    push(1, 8'h60, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = tx_valid && tx_ready;
    end
    check("hold_seen", 32'(seen), 32'd1);
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("hold_timeout", cnt, 8);

    // Asynchronous reset during SEND
    @(posedge clk); #1;
    tx_ready = 1'b0;
    push(2, 8'h70, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = tx_valid;
    end
    check("mid_send", {seen, busy}, 2'b11);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", {tx_valid, busy, grant_id}, '0);
    for (int r = 0; r < 4; r++) push(r, 8'(8'h80 + r), 1'b1);
    @(negedge clk);
    check("rst_rdy", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    base = log_cnt;
    rst = 1'b1;
    tx_ready = 1'b1;
    wait_drain("rst");
    check("rst_cnt", log_cnt - base, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("rst_order%0d", k), 32'(log_data[base + k]), 32'(exp_rst[k]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
